alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Shares one registered alu among NUM_REQ requesters, with one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_opcode,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [7:0]             resp_data,
    output logic                   resp_err,
    output logic                   alu_enable,
    output logic [2:0]             alu_opcode,
    output logic [7:0]             alu_input1,
    output logic [7:0]             alu_input2,
    input  logic [7:0]             alu_output
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [2:0] LAST_LEGAL_OP = 3'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic          found;
    logic          req_accept;
    logic          resp_handshake;
    logic [2:0]    sel_op;
    logic [7:0]    sel_a, sel_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest requesting index is the last write and wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr;
    int            rr_idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req_valid[rr_idx]) begin
                found  = 1'b1;
                winner = IW'(rr_idx);
            end
        end
    end

    // Pointer moves past the owner only when its response is actually taken.
    always_ff @(posedge clock) begin
        if (reset)
            ptr <= '0;
        else if (resp_handshake)
            ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    end
`endif

    assign sel_op         = req_opcode[3*int'(winner) +: 3];
    assign sel_a          = req_a[8*int'(winner) +: 8];
    assign sel_b          = req_b[8*int'(winner) +: 8];
    assign req_accept     = (state == IDLE) && found;
    assign resp_handshake = (state == RESP) && resp_ready[owner];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        alu_enable = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_next        = (sel_op <= LAST_LEGAL_OP) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                alu_enable = 1'b1;
                state_next = WAIT;
            end
            WAIT: state_next = RESP;
            RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner])
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            alu_opcode <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (req_accept) begin
                owner      <= winner;
                alu_opcode <= sel_op;
                alu_input1 <= sel_a;
                alu_input2 <= sel_b;
                // Illegal opcodes bypass the alu and answer straight from here.
                if (sel_op > LAST_LEGAL_OP) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end
            end
            if (state == WAIT) begin
                resp_data <= alu_output;
                resp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses, a monitor pops at each handshake.
// Contention expectations follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;

    localparam int N = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [3*N-1:0]   req_opcode = '0;
    logic [8*N-1:0]   req_a = '0;
    logic [8*N-1:0]   req_b = '0;
    logic [N-1:0]     resp_valid;
    logic [N-1:0]     resp_ready = '1;
    logic [7:0]       resp_data;
    logic             resp_err;
    logic             alu_enable;
    logic [2:0]       alu_opcode;
    logic [7:0]       alu_input1;
    logic [7:0]       alu_input2;
    logic [7:0]       alu_output = '0;

    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       err;
        int         gcyc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   alu_en_count = 0;
    int   last_grant_cyc = 0;
    int   first_cyc = 0;
    bit   prev_valid = 1'b0;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode),
        .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_output(alu_output)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // External alu: registered add/sub/mul, 8-bit truncated.
    always @(posedge clock) begin
        if (alu_enable) begin
            alu_en_count++;
            case (alu_opcode)
                3'd0:    alu_output <= alu_input1 + alu_input2;
                3'd1:    alu_output <= alu_input1 - alu_input2;
                3'd2:    alu_output <= 8'($signed(alu_input1) * $signed(alu_input2));
                default: alu_output <= 8'h00;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares each accepted response against the oldest expectation.
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else if (resp_valid != '0) begin
            if (!prev_valid) first_cyc = cyc;
            check("resp_onehot", 32'($onehot(resp_valid)), 32'd1);
            if ((resp_valid & resp_ready) != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", 32'(resp_valid), 32'(1 << e.owner));
                    check("resp_data", 32'(resp_data), 32'(e.data));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_latency", 32'(first_cyc - e.gcyc), 32'(e.lat));
                end
                prev_valid = 1'b0;
            end else begin
                prev_valid = 1'b1;
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset     = 1'b1;
        req_valid = '0;
        resp_ready = '1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_opcode[3*idx +: 3] = op;
        req_a[8*idx +: 8]      = a;
        req_b[8*idx +: 8]      = b;
    endtask

    task automatic wait_grant(input int exp_idx);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            if (req_ready != '0) seen = 1'b1;
        end
        check("grant_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("grant_idx", 32'(req_ready), 32'(1 << exp_idx));
            last_grant_cyc = cyc;
        end
    endtask

    task automatic push(input int owner, input logic [7:0] data, input logic err);
        sb.push_back('{owner, data, err, last_grant_cyc, err ? 1 : 3});
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int k = 0; k < 60 && !empty; k++) begin
            @(negedge clock);
            if (sb.size() == 0) empty = 1'b1;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_req(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] data, input logic err);
        step();
        set_req(idx, op, a, b);
        req_valid = N'(1 << idx);
        wait_grant(idx);
        push(idx, data, err);
        step();
        req_valid = '0;
        drain();
    endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
    int         order[5]    = '{0, 0, 0, 0, 0};
    logic [7:0] rr_data[5]  = '{8'd11, 8'd11, 8'd11, 8'd11, 8'd11};
`else
    int         order[5]    = '{0, 1, 2, 3, 0};
    logic [7:0] rr_data[5]  = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd11};
`endif

    initial begin
        int  en_before;
        bit  found;
        bit  any_resp;

        do_reset();
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_alu_enable", 32'(alu_enable), 32'd0);
        check("rst_alu_regs", {8'd0, 5'd0, alu_opcode, alu_input1, alu_input2}, 32'd0);

        // Single request: 5 + 3, alu pulse one cycle after the grant.
        step();
        set_req(0, 3'd0, 8'd5, 8'd3);
        req_valid = 4'b0001;
        wait_grant(0);
        push(0, 8'd8, 1'b0);
        step();
        req_valid = '0;
        @(negedge clock);
        check("issue_alu_enable", 32'(alu_enable), 32'd1);
        check("issue_alu_operands", {13'd0, alu_opcode, alu_input1, alu_input2}, {13'd0, 3'd0, 8'd5, 8'd3});
        @(negedge clock);
        check("wait_alu_enable", 32'(alu_enable), 32'd0);
        check("wait_resp_valid", 32'(resp_valid), 32'd0);
        drain();

        // Signed overflow / truncation and further arithmetic.
        do_req(3, 3'd2, 8'hFC, 8'd50, 8'h38, 1'b0);
        do_req(0, 3'd1, 8'h80, 8'd1,  8'h7F, 1'b0);
        do_req(3, 3'd1, 8'd5,  8'd3,  8'h02, 1'b0);
        do_req(0, 3'd2, 8'd7,  8'hFD, 8'hEB, 1'b0);

        // Illegal opcode never reaches the alu.
        en_before = alu_en_count;
        do_req(1, 3'd5, 8'd7, 8'd9, 8'h00, 1'b1);
        check("illegal_no_alu", 32'(alu_en_count), 32'(en_before));

        // Backpressure on requester 2 while others request.
        step();
        resp_ready = 4'b1011;
        set_req(2, 3'd0, 8'd10, 8'd20);
        req_valid = 4'b0100;
        wait_grant(2);
        push(2, 8'd30, 1'b0);
        step();
        req_valid = 4'b1011;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            if (resp_valid != '0) found = 1'b1;
        end
        check("bp_resp_seen", 32'(found), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", 32'(resp_valid), 32'b0100);
            check("bp_resp_data", 32'(resp_data), 32'd30);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_alu_enable", 32'(alu_enable), 32'd0);
            @(negedge clock);
        end
        step();
        resp_ready = '1;
        req_valid  = '0;
        drain();

        // Contention from a fresh reset so the pointer starts at 0.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 3'd0, 8'(i + 1), 8'd10);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(order[k]);
            push(order[k], rr_data[k], 1'b0);
        end
        step();
        req_valid = '0;
        drain();

        // Reset while the request sits in WAIT: abandoned, outputs cleared, pointer back to 0.
        step();
        set_req(2, 3'd0, 8'd1, 8'd1);
        req_valid = 4'b0100;
        wait_grant(2);
        step();
        req_valid = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp", {23'd0, resp_err, resp_data}, 32'd0);
        check("mid_rst_alu", {7'd0, alu_enable, 3'd0, alu_opcode, alu_input1, alu_input2}, 32'd0);
        any_resp = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (resp_valid != '0) any_resp = 1'b1;
        end
        check("mid_rst_no_resp", 32'(any_resp), 32'd0);
        step();
        req_valid = '1;
        wait_grant(0);
        push(0, 8'd11, 1'b0);
        step();
        req_valid = '0;
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
